// File: rtl/mem_sched_pkg.sv
// rtl/mem_sched_pkg.sv - shared types and default parameters for the memory scheduler
// Purpose : DMA state encoding and bus-width / trigger-address defaults used by
//           mem_sched and mem_sched_dma.
// Ports   : none (package)
package mem_sched_pkg;

  localparam int REG_WIDTH      = 8;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = REG_WIDTH;
  localparam int DEF_DMA_LEN    = 256;
  localparam logic [15:0] DEF_DMA_TRIG_ADDR = 16'h4014;

  // Raw encodings kept for code that still compares against plain vectors.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ALIGN = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    DMA_IDLE  = ST_IDLE,
    DMA_ALIGN = ST_ALIGN,
    DMA_RUN   = ST_RUN,
    DMA_DRAIN = ST_DRAIN
  } dma_state_e;

endpackage

// File: rtl/mem_sched_dma.sv
// rtl/mem_sched_dma.sv - OAM DMA engine: FSM, page/index counters, OAM write pipeline
// Purpose : Copies DMA_LEN bytes from page {page, 8'hxx} into OAM, one read per
//           granted cycle, writing OAM the cycle after each read.
//           Optional macro MEM_SCHED_DMA_ALIGN_EN adds a free-running parity bit;
//           a trigger accepted on odd parity stretches ALIGN to two cycles.
// Ports   : clk, reset_n        clock, synchronous active-low reset
//           i_trig, i_trig_page trigger strobe and page number (CPU write data)
//           i_preempt           loader owns the memory port this cycle
//           o_dma_req/o_dma_addr read request and address for the priority mux
//           o_idle, o_busy      FSM is / is not in IDLE
//           o_oam_we/o_oam_addr OAM write strobe and byte index
module mem_sched_dma
  import mem_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DMA_LEN    = DEF_DMA_LEN
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_trig,
  input  logic [DATA_WIDTH-1:0] i_trig_page,
  input  logic                  i_preempt,
  output logic                  o_dma_req,
  output logic [ADDR_WIDTH-1:0] o_dma_addr,
  output logic                  o_idle,
  output logic                  o_busy,
  output logic                  o_oam_we,
  output logic [7:0]            o_oam_addr
);

  localparam int         PAGE_W   = ADDR_WIDTH - 8;
  localparam logic [7:0] IDX_MASK = 8'(DMA_LEN - 1);

  dma_state_e        r_state;
  logic [PAGE_W-1:0] r_page;
  logic [7:0]        r_idx;
  logic [7:0]        r_oam_idx;
  logic              r_oam_pend;
  logic              w_read;
`ifdef MEM_SCHED_DMA_ALIGN_EN
  logic              r_parity;
  logic              r_align_extra;
`endif

  // A read goes out only in RUN and only when the loader is not on the port.
  assign w_read     = (r_state == DMA_RUN) && !i_preempt;
  assign o_dma_req  = (r_state == DMA_RUN);
  assign o_dma_addr = {r_page, r_idx};
  assign o_idle     = (r_state == DMA_IDLE);
  assign o_busy     = (r_state != DMA_IDLE);
  assign o_oam_we   = r_oam_pend;
  assign o_oam_addr = r_oam_idx;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= DMA_IDLE;
      r_page     <= '0;
      r_idx      <= '0;
      r_oam_idx  <= '0;
      r_oam_pend <= 1'b0;
`ifdef MEM_SCHED_DMA_ALIGN_EN
      r_parity      <= 1'b0;
      r_align_extra <= 1'b0;
`endif
    end else begin
`ifdef MEM_SCHED_DMA_ALIGN_EN
      r_parity <= ~r_parity;
`endif
      // OAM write lands one cycle after its read, when mem_rdata is valid.
      r_oam_pend <= w_read;
      if (w_read) begin
        r_oam_idx <= r_idx;
      end
      case (r_state)
        DMA_IDLE: begin
          if (i_trig) begin
            r_page  <= PAGE_W'(i_trig_page);
            r_idx   <= '0;
            r_state <= DMA_ALIGN;
`ifdef MEM_SCHED_DMA_ALIGN_EN
            r_align_extra <= r_parity;
`endif
          end
        end
        DMA_ALIGN: begin
`ifdef MEM_SCHED_DMA_ALIGN_EN
          if (r_align_extra) begin
            r_align_extra <= 1'b0;
          end else begin
            r_state <= DMA_RUN;
          end
`else
          r_state <= DMA_RUN;
`endif
        end
        DMA_RUN: begin
          if (w_read) begin
            // Index wraps inside the page; it never carries into r_page.
            r_idx <= (r_idx + 8'd1) & IDX_MASK;
            if (r_idx == IDX_MASK) begin
              r_state <= DMA_DRAIN;
            end
          end
        end
        DMA_DRAIN: r_state <= DMA_IDLE;
        default:   r_state <= DMA_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_sched.sv
// rtl/mem_sched.sv - single-port memory scheduler for loader, OAM DMA and CPU
// Purpose : Grants one memory access per cycle, loader > DMA > CPU. A CPU write
//           to DMA_TRIG_ADDR starts a page-to-OAM copy and stalls the CPU until
//           it finishes. Build option MEM_SCHED_DMA_ALIGN_EN (see mem_sched_dma).
// Ports   : clk, reset_n                          clock, sync active-low reset
//           cpu_req/we/addr/wdata, cpu_rdy/rdata  CPU port
//           ld_valid/addr/data, ld_ready          loader write port
//           mem_en/we/addr/wdata, mem_rdata       flat memory port (1-cycle read)
//           oam_we/addr/wdata                     OAM write port
//           dma_busy                              DMA in progress
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int                    DMA_LEN       = DEF_DMA_LEN,
  parameter logic [ADDR_WIDTH-1:0] DMA_TRIG_ADDR = DEF_DMA_TRIG_ADDR
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_rdy,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  oam_we,
  output logic [7:0]            oam_addr,
  output logic [DATA_WIDTH-1:0] oam_wdata,
  output logic                  dma_busy
);

  logic                  w_dma_req;
  logic [ADDR_WIDTH-1:0] w_dma_addr;
  logic                  w_dma_idle;
  logic                  w_dma_busy;
  logic                  w_oam_we;
  logic [7:0]            w_oam_addr;
  logic                  w_dma_go;
  logic                  w_cpu_go;
  logic                  w_trig;
  logic                  r_rd_pend;
  logic [DATA_WIDTH-1:0] r_rdata;

  assign w_dma_go = w_dma_req && !ld_valid;
  assign w_cpu_go = cpu_req && !ld_valid && w_dma_idle;
  assign w_trig   = w_cpu_go && cpu_we && (cpu_addr == DMA_TRIG_ADDR);

  mem_sched_dma #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DMA_LEN    (DMA_LEN)
  ) u_dma (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_trig      (w_trig),
    .i_trig_page (cpu_wdata),
    .i_preempt   (ld_valid),
    .o_dma_req   (w_dma_req),
    .o_dma_addr  (w_dma_addr),
    .o_idle      (w_dma_idle),
    .o_busy      (w_dma_busy),
    .o_oam_we    (w_oam_we),
    .o_oam_addr  (w_oam_addr)
  );

  // All outputs are forced low while reset_n is asserted, so an in-flight
  // OAM write or memory strobe never escapes in the reset cycle.
  assign cpu_rdy   = reset_n && w_cpu_go;
  assign ld_ready  = reset_n && ld_valid;
  assign dma_busy  = reset_n && w_dma_busy;
  assign oam_we    = reset_n && w_oam_we;
  assign oam_addr  = oam_we ? w_oam_addr : 8'd0;
  assign oam_wdata = oam_we ? mem_rdata : '0;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset_n) begin
      if (ld_valid) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ld_addr;
        mem_wdata = ld_data;
      end else if (w_dma_go) begin
        mem_en   = 1'b1;
        mem_addr = w_dma_addr;
      end else if (w_cpu_go && !w_trig) begin
        // The trigger write is consumed here and never reaches memory.
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_we ? cpu_wdata : '0;
      end
    end
  end

  // Read data is presented straight from memory in the cycle after the
  // accepted read and captured so it stays put until the next CPU read.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_pend <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rd_pend <= w_cpu_go && !cpu_we;
      if (r_rd_pend) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  assign cpu_rdata = !reset_n ? '0 : (r_rd_pend ? mem_rdata : r_rdata);

endmodule

// File: tb/tb_mem_sched.sv
// tb/tb_mem_sched.sv - self-checking bench for mem_sched
`timescale 1ns/1ps
module tb_mem_sched;

  localparam int          AW   = 16;
  localparam int          DW   = 8;
  localparam int          LEN  = 256;
  localparam logic [15:0] TRIG = 16'h4014;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_rdy;
  logic [DW-1:0] cpu_rdata;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          oam_we;
  logic [7:0]    oam_addr;
  logic [DW-1:0] oam_wdata;
  logic          dma_busy;

  mem_sched #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .DMA_LEN       (LEN),
    .DMA_TRIG_ADDR (TRIG)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdy   (cpu_rdy),
    .cpu_rdata (cpu_rdata),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .oam_we    (oam_we),
    .oam_addr  (oam_addr),
    .oam_wdata (oam_wdata),
    .dma_busy  (dma_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int since_rst = 0;
  int acc_par = 0;

  logic [7:0] mem_arr [0:65535];
  logic [7:0] ref_mem [0:65535];

  // Flat memory behind the scheduler, 1-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset_n) since_rst <= 0;
    else since_rst <= since_rst + 1;
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else mem_rdata <= mem_arr[mem_addr];
    end
  end

  int         oam_cyc[$];
  logic [7:0] oam_a[$];
  logic [7:0] oam_d[$];
  int         rd_cyc[$];
  int         rise_cyc[$];
  int         last_busy = -1;
  int         trig_wr = 0;
  int         rdy_in_busy = 0;
  logic       prev_busy = 1'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (oam_we) begin
        oam_cyc.push_back(cyc);
        oam_a.push_back(oam_addr);
        oam_d.push_back(oam_wdata);
      end
      if (mem_en && mem_we && mem_addr == TRIG) trig_wr <= trig_wr + 1;
      if (dma_busy && cpu_rdy) rdy_in_busy <= rdy_in_busy + 1;
      if (mem_en && !mem_we && dma_busy) rd_cyc.push_back(cyc);
      if (dma_busy && !prev_busy) rise_cyc.push_back(cyc);
      if (dma_busy) last_busy <= cyc;
    end
    prev_busy <= dma_busy;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_op(input logic we, input logic [15:0] a, input logic [7:0] d, output int t);
    logic is_trig;
    is_trig = we && (a == TRIG);
    t = -1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    for (int n = 0; n < 600 && t < 0; n++) begin
      @(negedge clk);
      if (cpu_rdy) begin
        t = cyc;
        acc_par = since_rst % 2;
        check("cpu_mem_en", 32'(mem_en), is_trig ? 0 : 1);
        if (!is_trig) begin
          check("cpu_mem_we", 32'(mem_we), 32'(we));
          check("cpu_mem_addr", 32'(mem_addr), 32'(a));
        end
      end
      step();
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    check("cpu_accept_timeout", 32'(t >= 0), 1);
    if (t >= 0 && we && !is_trig) ref_mem[a] = d;
  endtask

  task automatic run_dma(input logic [7:0] page, input int npre, input logic hold, input logic contend);
    int t, extra, base_o, base_r, base_rise, trig0, rdy0, acc, o1, o3, e_fall, bad, cnt, k;
    base_o = oam_cyc.size(); base_r = rd_cyc.size(); base_rise = rise_cyc.size();
    trig0 = trig_wr; rdy0 = rdy_in_busy;
    o1 = int'($urandom_range(10, 80));
    o3 = int'($urandom_range(120, 240));
    if (contend) begin
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = TRIG; cpu_wdata = page;
      ld_valid = 1'b1; ld_addr = 16'h0600; ld_data = 8'($urandom);
      ref_mem[16'h0600] = ld_data;
      @(negedge clk);
      check("contend_cpu_rdy", 32'(cpu_rdy), 0);
      check("contend_mem_addr", 32'(mem_addr), 32'h0600);
      step();
      ld_valid = 1'b0; cpu_req = 1'b0;
      @(negedge clk);
      check("contend_no_busy", 32'(dma_busy), 0);
      step();
    end
    cpu_op(1'b1, TRIG, page, t);
    extra = 0;
`ifdef MEM_SCHED_DMA_ALIGN_EN
    extra = acc_par;
`endif
    e_fall = t + 3 + LEN + npre + extra;
    acc = -1;
    if (hold) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200; end
    while (t >= 0 && cyc <= e_fall + 4) begin
      k = cyc - t;
      if ((npre > 0 && k == o1) || (npre > 1 && k == o1 + 1) || (npre > 2 && k == o3)) begin
        ld_valid = 1'b1; ld_addr = 16'(16'h0500 + k); ld_data = 8'($urandom);
        ref_mem[ld_addr] = ld_data;
      end else begin
        ld_valid = 1'b0;
      end
      @(negedge clk);
      if (hold && acc < 0 && cpu_rdy) acc = cyc;
      if (hold && acc >= 0 && cyc == acc + 1) check("hold_rdata", 32'(cpu_rdata), 32'(ref_mem[16'h0200]));
      step();
      if (acc >= 0) cpu_req = 1'b0;
    end
    ld_valid = 1'b0; cpu_req = 1'b0;
    cnt = oam_cyc.size() - base_o;
    check("busy_rise", rise_cyc.size() > base_rise ? rise_cyc[base_rise] : -1, t + 1);
    check("first_dma_read", rd_cyc.size() > base_r ? rd_cyc[base_r] : -1, t + 2 + extra);
    check("oam_count", cnt, LEN);
    check("first_oam", cnt > 0 ? oam_cyc[base_o] : -1, t + 3 + extra);
    check("last_oam", cnt > 0 ? oam_cyc[oam_cyc.size() - 1] : -1, t + 2 + LEN + npre + extra);
    check("busy_fall", last_busy + 1, e_fall);
    bad = 0;
    for (int i = 0; i < cnt; i++) begin
      if (oam_a[base_o + i] !== 8'(i) || oam_d[base_o + i] !== ref_mem[{page, 8'(i)}]) bad++;
    end
    check("oam_content_mismatches", bad, 0);
    check("trig_mem_writes", trig_wr - trig0, 0);
    check("cpu_rdy_while_busy", rdy_in_busy - rdy0, 0);
    if (hold) check("hold_accept_cycle", acc, e_fall);
  endtask

  initial begin
    int t, bad;
    logic [7:0] v, w, rp;
    v  = 8'($urandom_range(1, 254));
    w  = v ^ 8'hFF;
    rp = 8'($urandom_range(7, 63));

    // Busy inputs during reset: every output must still read zero.
    reset_n = 1'b0;
    ld_valid = 1'b1; ld_addr = 16'h1234; ld_data = 8'hA5;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'h11;
    repeat (3) step();
    @(negedge clk);
    check("rst_cpu_rdy", 32'(cpu_rdy), 0);
    check("rst_ld_ready", 32'(ld_ready), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_oam_we", 32'(oam_we), 0);
    check("rst_oam_addr", 32'(oam_addr), 0);
    check("rst_oam_wdata", 32'(oam_wdata), 0);
    check("rst_dma_busy", 32'(dma_busy), 0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 0);
    step();
    reset_n = 1'b1; ld_valid = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    step();

    // Plain CPU write then read-back, twice with different data.
    cpu_op(1'b1, 16'h0200, v, t);
    check("mem_write_0200", 32'(mem_arr[16'h0200]), 32'(v));
    cpu_op(1'b0, 16'h0200, 8'h00, t);
    @(negedge clk);
    check("cpu_rdata_0200", 32'(cpu_rdata), 32'(v));
    step(); step();
    @(negedge clk);
    check("cpu_rdata_hold", 32'(cpu_rdata), 32'(v));
    step();
    cpu_op(1'b1, 16'h0201, w, t);
    cpu_op(1'b0, 16'h0201, 8'h00, t);
    @(negedge clk);
    check("cpu_rdata_0201", 32'(cpu_rdata), 32'(w));
    step();

    // Loader fills page 3 with its low address byte and a random page with noise.
    for (int i = 0; i < 256; i++) begin
      ld_valid = 1'b1; ld_addr = {8'h03, 8'(i)}; ld_data = 8'(i);
      ref_mem[ld_addr] = ld_data;
      if (i == 0) begin
        @(negedge clk);
        check("ld_ready", 32'(ld_ready), 1);
        check("ld_mem_we", 32'(mem_we), 1);
      end
      step();
    end
    for (int i = 0; i < 256; i++) begin
      ld_valid = 1'b1; ld_addr = {rp, 8'(i)}; ld_data = 8'($urandom);
      ref_mem[ld_addr] = ld_data;
      step();
    end
    ld_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem_arr[{8'h03, 8'(i)}] !== ref_mem[{8'h03, 8'(i)}]) bad++;
      if (mem_arr[{rp, 8'(i)}] !== ref_mem[{rp, 8'(i)}]) bad++;
    end
    check("loader_fill_mismatches", bad, 0);
    step();

    run_dma(8'h03, 0, 1'b0, 1'b0);
    run_dma(8'h03, 3, 1'b0, 1'b0);
    run_dma(rp, 0, 1'b1, 1'b1);
    run_dma(rp, 2, 1'b0, 1'b0);

    // Reset in the middle of a copy aborts it cleanly.
    cpu_op(1'b0, 16'h0201, 8'h00, t);
    cpu_op(1'b1, TRIG, rp, t);
    while (cyc < t + 100) step();
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_oam_we", 32'(oam_we), 0);
    check("midrst_busy", 32'(dma_busy), 0);
    check("midrst_mem_en", 32'(mem_en), 0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("postrst_oam_we", 32'(oam_we), 0);
    check("postrst_busy", 32'(dma_busy), 0);
    check("postrst_mem_en", 32'(mem_en), 0);
    check("postrst_cpu_rdata", 32'(cpu_rdata), 0);
    step();
    run_dma(8'h03, int'($urandom_range(0, 3)), 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
